sequencer_fsm: RTL and testbench
================================

# sequencer_fsm

LUT-programmed sequencer for the panel acquisition chain. A host loads a small lookup table of steps; the block then replays them continuously. Each step names a state, a dwell length and a repeat count, and the block drives one-hot enables for the panel power, bias, flush, AED, expose and readout sub-blocks. It sits between the register/host interface and the panel timing blocks.

## Interface
- `LUT_DEPTH`, 8: number of LUT entries; address width is `$clog2(LUT_DEPTH)`.
- `clk` in 1: single clock, rising edge.
- `reset_i` in 1: asynchronous, active-low reset.
- `lut_wen_i` in 1: write strobe; one entry written per cycle.
- `lut_write_data_i` in 29: entry `{sof[28], eof[27], data_length[26:11], repeat_count[10:3], next_state[2:0]}`.
- `lut_rden_i` in 1: readback strobe.
- `lut_read_data_o` out 29: readback data.
- `current_state_o` out 3: state code. RST=0, IDLE=1, PANEL_STABLE=2, BACK_BIAS=3, FLUSH=4, AED_DETECT=5, EXPOSE_TIME=6, READOUT=7.
- `busy_o` out 1: a step is executing.
- `sequence_done_o` out 1: one-cycle end-of-sequence pulse.
- `panel_enable_o`, `bias_enable_o`, `flush_enable_o`, `expose_enable_o`, `readout_enable_o`, `aed_enable_o` out 1 each: state decodes.
- `current_repeat_count_o` out 8: repeats remaining in the current step, including the current one.
- `current_data_length_o` out 16: `data_length` of the current entry.
- `current_eof_o`, `current_sof_o` out 1 each: flags of the current entry.

## Operation
- **Reset values.** On reset assertion:
  - state=RST; write pointer, read pointer, entry count and `lut_addr_reg` are 0.
  - All outputs are 0.
  - LUT contents are not cleared, but count=0, so the LUT must be reloaded after every reset.
- **Loading (RST only).**
  - Each cycle with `lut_wen_i`=1 writes `lut[wr_ptr]`, then increments `wr_ptr` and the count.
  - Writes when count=`LUT_DEPTH` are ignored.
  - Writes outside RST are ignored.
- **RST to IDLE.** RST holds while `lut_wen_i`=1 or count=0; otherwise it moves to IDLE.
- **IDLE.** Lasts one cycle. It sets `lut_addr_reg`=0 and loads entry 0.
- **Step execution.**
  - The FSM enters `entry.next_state`; RST is treated as IDLE.
  - The step holds for `data_length` cycles, repeated `repeat_count` times. A value of 0 in either field is treated as 1.
  - Within a step, `current_repeat_count_o` starts at `repeat_count` and decrements at each dwell boundary.
- **End of step.**
  - If the entry has `eof`=1, or `lut_addr_reg`=count-1: go to IDLE, pulse `sequence_done_o` in that IDLE cycle, then restart from entry 0.
  - Otherwise: increment `lut_addr_reg` and load the next entry with no bubble cycle.
- **Output decodes.**
  - `busy_o`=1 in any executing step, including an IDLE dwell step.
  - Each enable equals (state == its state), for example `panel_enable_o` = (state==PANEL_STABLE).
  - The current-entry outputs are 0 in RST and in the one-cycle IDLE.
- **Readback.** `lut_rden_i`=1 gives `lut_read_data_o`=`lut[rd_ptr]` on the next cycle, and `rd_ptr` increments, wrapping at `LUT_DEPTH`. The output holds its value otherwise.

## Timing
- All outputs are registered and change on the `clk` edge that enters the new state.
- A step occupies exactly `repeat_count`×`data_length` cycles.
- Sequence period = 1 (IDLE) + Σ(`repeat_count`×`data_length`).
- Readback latency: 1 cycle.
- Reset assertion mid-sequence returns the block to RST asynchronously, with all outputs 0.

## Configuration
- **With `SEQUENCER_FSM_LUT_READBACK_EN` defined:** the readback port and `rd_ptr` exist.
- **Without it:** `lut_read_data_o` is tied to 0 and `lut_rden_i` is ignored.

## Structure
- **Package `sequencer_fsm_pkg`** holds:
  - the state enum (3 bits);
  - the packed `lut_entry_t` struct;
  - field-width constants;
  - the entry width, 29.
- **Sub-module `sequencer_lut_ram`** holds the storage array, write pointer/count and readback port. The FSM and counters stay in `sequencer_fsm`.

## Test plan
- **Reset.** Reset low, then high, with no writes: stays in RST, all outputs 0, `busy_o`=0.
- **Full sequence.** Load the 6-entry sequence:
  - PANEL(2×50), BIAS(3×10), FLUSH(2×30), EXPOSE(1×50), READOUT(1×40), IDLE(1×20, eof).
  - Required: IDLE for 1 cycle, then PANEL_STABLE for 100 cycles with the repeat count going 2 then 1, and so on.
  - `sequence_done_o` pulses after 300 step cycles; the period is 301 cycles.
- **Zero fields.** An entry with `repeat_count`=0 and `data_length`=0 dwells exactly 1 cycle.
- **Overflow and late writes.** Write 9 entries with `LUT_DEPTH`=8: the 9th is ignored. A `lut_wen_i` during execution changes nothing.
- **Reset mid-operation.** Assert reset during READOUT: outputs are 0 immediately, the state is RST, and a reload is required.
- **Readback.** With readback enabled, 3 `lut_rden_i` pulses return entries 0, 1 and 2 with 1-cycle latency.

Source files
------------

// File: rtl/sequencer_fsm_pkg.sv
// Shared types for the LUT-programmed panel sequencer: state codes, LUT entry layout
// and the helpers that map zero-valued dwell/repeat fields to a single pass.
package sequencer_fsm_pkg;

  localparam int STATE_W  = 3;
  localparam int REPEAT_W = 8;
  localparam int LENGTH_W = 16;
  localparam int ENTRY_W  = 29;

  typedef enum logic [STATE_W-1:0] {
    ST_RST          = 3'd0,
    ST_IDLE         = 3'd1,
    ST_PANEL_STABLE = 3'd2,
    ST_BACK_BIAS    = 3'd3,
    ST_FLUSH        = 3'd4,
    ST_AED_DETECT   = 3'd5,
    ST_EXPOSE_TIME  = 3'd6,
    ST_READOUT      = 3'd7
  } state_t;

  typedef struct packed {
    logic                sof;
    logic                eof;
    logic [LENGTH_W-1:0] data_length;
    logic [REPEAT_W-1:0] repeat_count;
    state_t              next_state;
  } lut_entry_t;

  function automatic logic [REPEAT_W-1:0] eff_repeat(input lut_entry_t e);
    return (e.repeat_count == '0) ? REPEAT_W'(1) : e.repeat_count;
  endfunction

  // Cycles left in a dwell after its first cycle; a zero length still dwells once.
  function automatic logic [LENGTH_W-1:0] dwell_reload(input lut_entry_t e);
    return (e.data_length == '0) ? '0 : e.data_length - LENGTH_W'(1);
  endfunction

  function automatic state_t step_state(input state_t s);
    return (s == ST_RST) ? ST_IDLE : s;
  endfunction

endpackage

// File: rtl/sequencer_lut_ram.sv
// Step LUT storage with write pointer/count and an optional sequential readback port
// (present only when SEQUENCER_FSM_LUT_READBACK_EN is defined).
module sequencer_lut_ram
  import sequencer_fsm_pkg::*;
#(
  parameter int LUT_DEPTH = 8,
  parameter int AW        = $clog2(LUT_DEPTH),
  parameter int CW        = $clog2(LUT_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset_i,
  input  logic               wr_en,
  input  lut_entry_t         wr_entry,
  input  logic [AW-1:0]      fetch_addr,
  output lut_entry_t         fetch_entry,
  output logic [CW-1:0]      count,
  input  logic               rd_en,
  output logic [ENTRY_W-1:0] rd_data
);

  lut_entry_t    mem [LUT_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic          wr_accept;

  assign wr_accept = wr_en && (count != CW'(LUT_DEPTH));

  // NOTE: the storage array has no reset; the entry count gates its use, so a reset only clears count.
  always_ff @(posedge clk) begin
    if (wr_accept) mem[wr_ptr] <= wr_entry;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      wr_ptr <= '0;
      count  <= '0;
    end else if (wr_accept) begin
      wr_ptr <= (wr_ptr == AW'(LUT_DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
      count  <= count + CW'(1);
    end
  end

  // Combinational fetch lets the FSM chain steps without a bubble cycle.
  assign fetch_entry = mem[fetch_addr];

`ifdef SEQUENCER_FSM_LUT_READBACK_EN
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      rd_ptr  <= '0;
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_ptr];
      rd_ptr  <= (rd_ptr == AW'(LUT_DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
    end
  end
`else
  logic unused_rd_en;
  assign unused_rd_en = rd_en;
  assign rd_data      = '0;
`endif

endmodule

// File: rtl/sequencer_fsm.sv
// LUT-programmed panel acquisition sequencer: replays loaded steps with dwell/repeat timing.
// Define SEQUENCER_FSM_LUT_READBACK_EN to enable the LUT readback port.
module sequencer_fsm
  import sequencer_fsm_pkg::*;
#(
  parameter int LUT_DEPTH = 8
) (
  input  logic                clk,
  input  logic                reset_i,
  input  logic                lut_wen_i,
  input  logic [ENTRY_W-1:0]  lut_write_data_i,
  input  logic                lut_rden_i,
  output logic [ENTRY_W-1:0]  lut_read_data_o,
  output logic [STATE_W-1:0]  current_state_o,
  output logic                busy_o,
  output logic                sequence_done_o,
  output logic                panel_enable_o,
  output logic                bias_enable_o,
  output logic                flush_enable_o,
  output logic                expose_enable_o,
  output logic                readout_enable_o,
  output logic                aed_enable_o,
  output logic [REPEAT_W-1:0] current_repeat_count_o,
  output logic [LENGTH_W-1:0] current_data_length_o,
  output logic                current_eof_o,
  output logic                current_sof_o
);

  localparam int AW = $clog2(LUT_DEPTH);
  localparam int CW = $clog2(LUT_DEPTH + 1);

  state_t              state_q, state_d;
  logic [AW-1:0]       addr_q, addr_d, fetch_addr;
  lut_entry_t          entry_q, entry_d, fetch_entry;
  logic [LENGTH_W-1:0] dwell_q, dwell_d;
  logic [REPEAT_W-1:0] rep_q, rep_d;
  logic                busy_q, busy_d, done_q, done_d;
  logic [5:0]          en_q, en_d;
  logic [CW-1:0]       count;
  logic                last_step, load;

  sequencer_lut_ram #(.LUT_DEPTH(LUT_DEPTH), .AW(AW), .CW(CW)) u_lut (
    .clk         (clk),
    .reset_i     (reset_i),
    .wr_en       (lut_wen_i && (state_q == ST_RST)),
    .wr_entry    (lut_entry_t'(lut_write_data_i)),
    .fetch_addr  (fetch_addr),
    .fetch_entry (fetch_entry),
    .count       (count),
    .rd_en       (lut_rden_i),
    .rd_data     (lut_read_data_o)
  );

  // The non-busy IDLE cycle always starts the sequence from entry 0.
  assign fetch_addr = busy_q ? addr_q + AW'(1) : '0;
  assign last_step  = entry_q.eof || ((CW'(addr_q) + CW'(1)) == count);

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    entry_d = entry_q;
    dwell_d = dwell_q;
    rep_d   = rep_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    load    = 1'b0;
    if (state_q == ST_RST) begin
      if (!lut_wen_i && (count != '0)) state_d = ST_IDLE;
    end else if (!busy_q) begin
      load = 1'b1;
    end else if (dwell_q != '0) begin
      dwell_d = dwell_q - LENGTH_W'(1);
    end else if (rep_q > REPEAT_W'(1)) begin
      rep_d   = rep_q - REPEAT_W'(1);
      dwell_d = dwell_reload(entry_q);
    end else if (last_step) begin
      state_d = ST_IDLE;
      addr_d  = '0;
      entry_d = '0;
      rep_d   = '0;
      busy_d  = 1'b0;
      done_d  = 1'b1;
    end else begin
      load = 1'b1;
    end

    if (load) begin
      state_d = step_state(fetch_entry.next_state);
      addr_d  = fetch_addr;
      entry_d = fetch_entry;
      rep_d   = eff_repeat(fetch_entry);
      dwell_d = dwell_reload(fetch_entry);
      busy_d  = 1'b1;
    end

    en_d = {state_d == ST_PANEL_STABLE, state_d == ST_BACK_BIAS, state_d == ST_FLUSH,
            state_d == ST_AED_DETECT, state_d == ST_EXPOSE_TIME, state_d == ST_READOUT};
  end

  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= ST_RST;
      addr_q  <= '0;
      entry_q <= '0;
      dwell_q <= '0;
      rep_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      en_q    <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      entry_q <= entry_d;
      dwell_q <= dwell_d;
      rep_q   <= rep_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      en_q    <= en_d;
    end
  end

  assign current_state_o        = state_q;
  assign busy_o                 = busy_q;
  assign sequence_done_o        = done_q;
  assign {panel_enable_o, bias_enable_o, flush_enable_o,
          aed_enable_o, expose_enable_o, readout_enable_o} = en_q;
  assign current_repeat_count_o = rep_q;
  assign current_data_length_o  = entry_q.data_length;
  assign current_eof_o          = entry_q.eof;
  assign current_sof_o          = entry_q.sof;

endmodule

// File: tb/tb_sequencer_fsm.sv
// Self-checking bench for sequencer_fsm: decode table, cycle-exact trace model, corner sequences.
`timescale 1ns/1ps
module tb_sequencer_fsm;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset_i, lut_wen_i, lut_rden_i;
  logic [28:0] lut_write_data_i, lut_read_data_o;
  logic [2:0]  current_state_o;
  logic        busy_o, sequence_done_o;
  logic        panel_enable_o, bias_enable_o, flush_enable_o;
  logic        expose_enable_o, readout_enable_o, aed_enable_o;
  logic [7:0]  current_repeat_count_o;
  logic [15:0] current_data_length_o;
  logic        current_eof_o, current_sof_o;

  sequencer_fsm #(.LUT_DEPTH(DEPTH)) dut (
    .clk                    (clk),
    .reset_i                (reset_i),
    .lut_wen_i              (lut_wen_i),
    .lut_write_data_i       (lut_write_data_i),
    .lut_rden_i             (lut_rden_i),
    .lut_read_data_o        (lut_read_data_o),
    .current_state_o        (current_state_o),
    .busy_o                 (busy_o),
    .sequence_done_o        (sequence_done_o),
    .panel_enable_o         (panel_enable_o),
    .bias_enable_o          (bias_enable_o),
    .flush_enable_o         (flush_enable_o),
    .expose_enable_o        (expose_enable_o),
    .readout_enable_o       (readout_enable_o),
    .aed_enable_o           (aed_enable_o),
    .current_repeat_count_o (current_repeat_count_o),
    .current_data_length_o  (current_data_length_o),
    .current_eof_o          (current_eof_o),
    .current_sof_o          (current_sof_o)
  );

  always #5 clk = ~clk;

  // Enables ordered {panel, bias, flush, aed, expose, readout}.
  typedef struct packed {
    logic [2:0]  state;
    logic        busy;
    logic        done;
    logic [5:0]  en;
    logic [7:0]  rep;
    logic [15:0] len;
    logic        eof;
    logic        sof;
  } obs_t;

  typedef struct {
    logic [2:0]  ns;
    logic [7:0]  rc;
    logic [15:0] dl;
    logic [2:0]  exp_state;
    logic [5:0]  exp_en;
    int          exp_dwell;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  logic [28:0] model_lut[$];
  logic [28:0] pend_q[$];
  obs_t        trace_q[$];
  vec_t        vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [28:0] mk(input logic sof, input logic eof, input int dl,
                                     input int rc, input int ns);
    return {sof, eof, 16'(dl), 8'(rc), 3'(ns)};
  endfunction

  function automatic logic [5:0] en_of(input logic [2:0] st);
    case (st)
      3'd2:    return 6'b100000;
      3'd3:    return 6'b010000;
      3'd4:    return 6'b001000;
      3'd5:    return 6'b000100;
      3'd6:    return 6'b000010;
      3'd7:    return 6'b000001;
      default: return 6'b000000;
    endcase
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.state = current_state_o;
    o.busy  = busy_o;
    o.done  = sequence_done_o;
    o.en    = {panel_enable_o, bias_enable_o, flush_enable_o,
               aed_enable_o, expose_enable_o, readout_enable_o};
    o.rep   = current_repeat_count_o;
    o.len   = current_data_length_o;
    o.eof   = current_eof_o;
    o.sof   = current_sof_o;
    return o;
  endfunction

  // One sequence period as the block should present it, built straight from the step rules.
  task automatic build_trace();
    obs_t        o;
    logic [28:0] e;
    logic [2:0]  st;
    int          reps, len;
    bit          stop;
    trace_q.delete();
    o = '0;
    o.state = 3'd1;
    trace_q.push_back(o);
    stop = 1'b0;
    for (int a = 0; a < model_lut.size() && !stop; a++) begin
      e    = model_lut[a];
      st   = (e[2:0] == 3'd0) ? 3'd1 : e[2:0];
      reps = (e[10:3] == 8'd0) ? 1 : int'(e[10:3]);
      len  = (e[26:11] == 16'd0) ? 1 : int'(e[26:11]);
      for (int r = reps; r >= 1; r--) begin
        for (int c = 0; c < len; c++) begin
          o       = '0;
          o.state = st;
          o.busy  = 1'b1;
          o.en    = en_of(st);
          o.rep   = 8'(r);
          o.len   = e[26:11];
          o.eof   = e[27];
          o.sof   = e[28];
          trace_q.push_back(o);
        end
      end
      stop = e[27];
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_i    = 1'b0;
    lut_wen_i  = 1'b0;
    lut_rden_i = 1'b0;
    model_lut.delete();
    repeat (2) @(negedge clk);
    reset_i = 1'b1;
  endtask

  task automatic load_pending();
    foreach (pend_q[i]) begin
      lut_wen_i        = 1'b1;
      lut_write_data_i = pend_q[i];
      if (model_lut.size() < DEPTH) model_lut.push_back(pend_q[i]);
      @(negedge clk);
    end
    lut_wen_i = 1'b0;
    pend_q.delete();
  endtask

  // Compares every cycle of 'periods' periods right after a load; junk drives ignored writes.
  task automatic run_trace(input string tag, input int periods, input bit junk);
    obs_t exp;
    build_trace();
    for (int p = 0; p < periods; p++) begin
      for (int i = 0; i < trace_q.size(); i++) begin
        @(negedge clk);
        exp = trace_q[i];
        if (i == 0) exp.done = (p > 0);
        check($sformatf("%s p%0d c%0d", tag, p, i), 64'(sample()), 64'(exp));
        if (junk) begin
          lut_wen_i        = 1'($urandom_range(0, 1));
          lut_write_data_i = 29'($urandom);
        end
      end
    end
    lut_wen_i = 1'b0;
  endtask

  task automatic load_full();
    pend_q = {mk(1, 0, 50, 2, 2), mk(0, 0, 10, 3, 3), mk(0, 0, 30, 2, 4),
              mk(0, 0, 50, 1, 6), mk(0, 0, 40, 1, 7), mk(0, 1, 20, 1, 1)};
    load_pending();
  endtask

  initial begin
    int n;
    vecs[0] = '{3'd0, 8'd1, 16'd2, 3'd1, 6'b000000, 2};
    vecs[1] = '{3'd1, 8'd1, 16'd1, 3'd1, 6'b000000, 1};
    vecs[2] = '{3'd2, 8'd2, 16'd3, 3'd2, 6'b100000, 6};
    vecs[3] = '{3'd3, 8'd1, 16'd4, 3'd3, 6'b010000, 4};
    vecs[4] = '{3'd4, 8'd0, 16'd0, 3'd4, 6'b001000, 1};
    vecs[5] = '{3'd5, 8'd0, 16'd5, 3'd5, 6'b000100, 5};
    vecs[6] = '{3'd6, 8'd3, 16'd0, 3'd6, 6'b000010, 3};
    vecs[7] = '{3'd7, 8'd2, 16'd2, 3'd7, 6'b000001, 4};

    reset_i          = 1'b0;
    lut_wen_i        = 1'b0;
    lut_rden_i       = 1'b0;
    lut_write_data_i = '0;
    #3;
    check("reset_outputs", 64'(sample()), 64'd0);
    check("reset_readdata", 64'(lut_read_data_o), 64'd0);
    repeat (2) @(negedge clk);
    reset_i = 1'b1;
    repeat (5) @(negedge clk);
    check("empty_lut_stays_rst", 64'(sample()), 64'd0);

    foreach (vecs[v]) begin
      do_reset();
      pend_q = {mk(1, 1, int'(vecs[v].dl), int'(vecs[v].rc), int'(vecs[v].ns))};
      load_pending();
      @(negedge clk);
      check($sformatf("vec%0d idle", v), 64'({current_state_o, busy_o}), 64'({3'd1, 1'b0}));
      @(negedge clk);
      check($sformatf("vec%0d state", v), 64'(current_state_o), 64'(vecs[v].exp_state));
      check($sformatf("vec%0d enables", v), 64'(sample().en), 64'(vecs[v].exp_en));
      n = 0;
      while (busy_o && n < 100) begin
        n++;
        @(negedge clk);
      end
      check($sformatf("vec%0d dwell", v), 64'(n), 64'(vecs[v].exp_dwell));
      check($sformatf("vec%0d done", v), 64'(sequence_done_o), 64'd1);
    end

    do_reset();
    load_full();
    run_trace("full", 2, 1'b0);
    @(negedge clk);
    check("full done_pulse", 64'(sequence_done_o), 64'd1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sequence_done_o && n < 1000);
    check("full period", 64'(n), 64'd301);

    lut_rden_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
`ifdef SEQUENCER_FSM_LUT_READBACK_EN
      check($sformatf("readback %0d", i), 64'(lut_read_data_o), 64'(model_lut[i]));
`else
      check($sformatf("readback_off %0d", i), 64'(lut_read_data_o), 64'd0);
`endif
    end
    lut_rden_i = 1'b0;
    @(negedge clk);
`ifdef SEQUENCER_FSM_LUT_READBACK_EN
    check("readback hold", 64'(lut_read_data_o), 64'(model_lut[2]));
`else
    check("readback_off hold", 64'(lut_read_data_o), 64'd0);
`endif

    n = 0;
    while (current_state_o != 3'd7 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("reach readout", 64'(current_state_o), 64'd7);
    #2 reset_i = 1'b0;
    #1;
    check("midop reset outputs", 64'(sample()), 64'd0);
    check("midop reset readdata", 64'(lut_read_data_o), 64'd0);
    @(negedge clk);
    reset_i = 1'b1;
    model_lut.delete();
    repeat (4) @(negedge clk);
    check("midop needs reload", 64'(sample()), 64'd0);
    load_full();
    run_trace("reload", 1, 1'b0);

    do_reset();
    pend_q = {mk(1, 0, 0, 0, 2), mk(0, 0, 2, 1, 3)};
    load_pending();
    run_trace("zero_fields", 2, 1'b0);

    do_reset();
    for (int i = 0; i < 9; i++)
      pend_q.push_back(mk(i == 0, 0, $urandom_range(1, 4), $urandom_range(1, 2), $urandom_range(0, 7)));
    load_pending();
    run_trace("overflow", 2, 1'b1);

    for (int t = 0; t < 6; t++) begin
      do_reset();
      n = $urandom_range(1, DEPTH);
      for (int i = 0; i < n; i++)
        pend_q.push_back(mk($urandom_range(0, 1), ($urandom_range(0, 5) == 0),
                            $urandom_range(0, 6), $urandom_range(0, 3), $urandom_range(0, 7)));
      load_pending();
      run_trace($sformatf("rand%0d", t), 2, 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
